// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the bus request register
//   STREAK_W    : width of the memory-grant streak counter (limit up to 15)
package mem_arb_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ_IF,
        REQ_MEM,
        WAIT_IF,
        WAIT_MEM,
        DRAIN
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Unified memory bus between the arbiter (master) and the memory (slave).
//   bus_req/we/be/addr/wdata : request side, driven by the master
//   bus_gnt                  : request accepted this cycle
//   bus_rvalid/rdata         : response (read data or write ack)
interface mem_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic            bus_req;
    logic            bus_we;
    logic [DW/8-1:0] bus_be;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [DW-1:0]   bus_rdata;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_streak.sv
// Saturating count of consecutive memory-stage grants while a fetch waits.
//   clk, rst   : clock, asynchronous active-low reset
//   i_inc      : a memory grant was made while fetch was requesting
//   i_clr      : fetch granted or fetch not requesting (wins over i_inc)
//   o_at_limit : streak has reached MAX, next grant belongs to fetch
module arb_streak_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    logic [STREAK_W-1:0] r_cnt;

    assign o_at_limit = (r_cnt == STREAK_W'(MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between fetch and the memory stage.
// One transaction outstanding at a time; memory stage has priority, but after
// MAX_MEM_STREAK consecutive memory grants with a fetch waiting, fetch wins.
//   clk, rst                      : clock, asynchronous active-low reset
//   if_req/addr/kill, if_valid/rdata            : fetch requester
//   mem_req/we/be/addr/wdata, mem_valid/rdata   : memory-stage requester
//   bus (mem_bus_if.master)       : unified memory bus
//   stall_if, stall_mem           : hazard-unit stalls (combinational)
//   conflict_cnt                  : cycles with both requests high
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_kill,
    output logic            if_valid,
    output logic [DW-1:0]   if_rdata,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [DW/8-1:0] mem_be,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    output logic            mem_valid,
    output logic [DW-1:0]   mem_rdata,
    mem_bus_if.master       bus,
    output logic            stall_if,
    output logic            stall_mem,
    output logic [31:0]     conflict_cnt
);

    arb_state_t      r_state;
    arb_state_t      w_next_state;
    logic            r_bus_we;
    logic [DW/8-1:0] r_bus_be;
    logic [AW-1:0]   r_bus_addr;
    logic [DW-1:0]   r_bus_wdata;
    logic [31:0]     r_conflict_cnt;
    logic            w_grant_mem;
    logic            w_grant_if;
    logic            w_if_valid;
    logic            w_mem_valid;
    logic            w_at_limit;
    owner_t          w_owner;

    arb_streak_ctr #(
        .MAX (MAX_MEM_STREAK)
    ) u_streak (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_grant_mem && if_req),
        .i_clr      (!if_req || w_grant_if),
        .o_at_limit (w_at_limit)
    );

    always_comb begin
        w_next_state = r_state;
        w_grant_mem  = 1'b0;
        w_grant_if   = 1'b0;
        w_if_valid   = 1'b0;
        w_mem_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant_mem = mem_req && !(if_req && w_at_limit);
                w_grant_if  = !w_grant_mem && if_req && !if_kill;
                if (w_grant_mem) begin
                    w_next_state = REQ_MEM;
                end else if (w_grant_if) begin
                    w_next_state = REQ_IF;
                end
            end
            REQ_IF: begin
                // A kill coinciding with gnt means the read is already on the
                // bus, so it has to be drained rather than abandoned.
                if (bus.bus_gnt) begin
                    if (bus.bus_rvalid) begin
                        w_next_state = IDLE;
                        w_if_valid   = !if_kill;
                    end else begin
                        w_next_state = if_kill ? DRAIN : WAIT_IF;
                    end
                end else if (if_kill) begin
                    w_next_state = IDLE;
                end
            end
            REQ_MEM: begin
                if (bus.bus_gnt) begin
                    if (bus.bus_rvalid) begin
                        w_next_state = IDLE;
                        w_mem_valid  = 1'b1;
                    end else begin
                        w_next_state = WAIT_MEM;
                    end
                end
            end
            WAIT_IF: begin
                if (bus.bus_rvalid) begin
                    w_next_state = IDLE;
                    w_if_valid   = !if_kill;
                end else if (if_kill) begin
                    w_next_state = DRAIN;
                end
            end
            WAIT_MEM: begin
                if (bus.bus_rvalid) begin
                    w_next_state = IDLE;
                    w_mem_valid  = 1'b1;
                end
            end
            DRAIN: begin
                if (bus.bus_rvalid) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        w_owner = w_grant_mem ? OWN_MEM : OWN_IF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bus request fields are captured once at grant and held until completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_we    <= 1'b0;
            r_bus_be    <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_grant_mem || w_grant_if) begin
            case (w_owner)
                OWN_MEM: begin
                    r_bus_we    <= mem_we;
                    r_bus_be    <= mem_be;
                    r_bus_addr  <= mem_addr;
                    r_bus_wdata <= mem_wdata;
                end
                default: begin
                    r_bus_we    <= 1'b0;
                    r_bus_be    <= '1;
                    r_bus_addr  <= if_addr;
                    r_bus_wdata <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conflict_cnt <= '0;
        end else if (if_req && mem_req) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign bus.bus_req   = (r_state == REQ_IF) || (r_state == REQ_MEM);
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;

    assign if_valid     = w_if_valid;
    assign mem_valid    = w_mem_valid;
    assign if_rdata     = bus.bus_rdata;
    assign mem_rdata    = bus.bus_rdata;
    assign stall_mem    = mem_req && !w_mem_valid;
    assign stall_if     = (if_req && !w_if_valid) || stall_mem;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change just after the falling
// edge, outputs are sampled 1 time unit later, well before the next rising edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic [31:0] conflict_cnt;

    int nchk;
    int nerr;

    mem_bus_if #(.AW(32), .DW(32)) u_bus ();

    mem_port_arbiter #(
        .AW             (32),
        .DW             (32),
        .MAX_MEM_STREAK (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_kill      (if_kill),
        .if_valid     (if_valid),
        .if_rdata     (if_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_valid    (mem_valid),
        .mem_rdata    (mem_rdata),
        .bus          (u_bus),
        .stall_if     (stall_if),
        .stall_mem    (stall_mem),
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_drv(input logic g, input logic v, input logic [31:0] d);
        u_bus.bus_gnt    = g;
        u_bus.bus_rvalid = v;
        u_bus.bus_rdata  = d;
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
        bus_drv(1'b0, 1'b0, 32'h0);

        // Reset state
        tick(); #1;
        chk("rst_bus_req", {31'd0, u_bus.bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, u_bus.bus_we}, 32'd0);
        chk("rst_bus_addr", u_bus.bus_addr, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_stall_if", {31'd0, stall_if}, 32'd0);
        chk("rst_stall_mem", {31'd0, stall_mem}, 32'd0);
        chk("rst_conflict", conflict_cnt, 32'd0);
        mem_req = 1'b1; #1;
        chk("rst_stall_mem_comb", {31'd0, stall_mem}, 32'd1);
        mem_req = 1'b0;
        tick(); rst = 1'b1; #1;

        // Lone fetch
        tick(); if_req = 1'b1; if_addr = 32'h100; #1;
        chk("f_stall_if_idle", {31'd0, stall_if}, 32'd1);
        chk("f_bus_req_idle", {31'd0, u_bus.bus_req}, 32'd0);
        tick(); bus_drv(1'b1, 1'b0, 32'h0); #1;
        chk("f_bus_req", {31'd0, u_bus.bus_req}, 32'd1);
        chk("f_bus_addr", u_bus.bus_addr, 32'h100);
        chk("f_bus_we", {31'd0, u_bus.bus_we}, 32'd0);
        chk("f_bus_be", {28'd0, u_bus.bus_be}, 32'hf);
        chk("f_if_valid_req", {31'd0, if_valid}, 32'd0);
        chk("f_stall_if_req", {31'd0, stall_if}, 32'd1);
        tick(); bus_drv(1'b0, 1'b1, 32'h00500093); #1;
        chk("f_if_valid", {31'd0, if_valid}, 32'd1);
        chk("f_if_rdata", if_rdata, 32'h00500093);
        chk("f_stall_if_done", {31'd0, stall_if}, 32'd0);
        chk("f_bus_req_wait", {31'd0, u_bus.bus_req}, 32'd0);
        tick(); if_req = 1'b0; bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("f_if_valid_once", {31'd0, if_valid}, 32'd0);
        chk("f_conflict", conflict_cnt, 32'd0);

        // Simultaneous requests: store first, then fetch
        tick();
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'hf; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
        #1;
        chk("s_stall_mem", {31'd0, stall_mem}, 32'd1);
        chk("s_stall_if", {31'd0, stall_if}, 32'd1);
        tick(); bus_drv(1'b1, 1'b1, 32'h0); #1;
        chk("s_bus_req", {31'd0, u_bus.bus_req}, 32'd1);
        chk("s_bus_we", {31'd0, u_bus.bus_we}, 32'd1);
        chk("s_bus_addr", u_bus.bus_addr, 32'h2000);
        chk("s_bus_wdata", u_bus.bus_wdata, 32'hDEADBEEF);
        chk("s_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("s_if_valid", {31'd0, if_valid}, 32'd0);
        chk("s_stall_mem_done", {31'd0, stall_mem}, 32'd0);
        chk("s_stall_if_held", {31'd0, stall_if}, 32'd1);
        tick(); mem_req = 1'b0; bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("s_bus_req_idle", {31'd0, u_bus.bus_req}, 32'd0);
        tick(); bus_drv(1'b1, 1'b1, 32'h11111111); #1;
        chk("s_if_bus_addr", u_bus.bus_addr, 32'h104);
        chk("s_if_bus_we", {31'd0, u_bus.bus_we}, 32'd0);
        chk("s_if_valid2", {31'd0, if_valid}, 32'd1);
        chk("s_if_rdata", if_rdata, 32'h11111111);
        tick(); if_req = 1'b0; bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("s_conflict", conflict_cnt, 32'd2);

        // Starvation limit: four memory loads, then the fetch, then memory again
        tick();
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000;
        for (int k = 1; k <= 4; k++) begin
            bus_drv(1'b0, 1'b0, 32'h0); #1;
            chk("sv_idle_req", {31'd0, u_bus.bus_req}, 32'd0);
            tick(); bus_drv(1'b1, 1'b1, 32'(k)); #1;
            chk("sv_mem_addr", u_bus.bus_addr, 32'h4000);
            chk("sv_mem_valid", {31'd0, mem_valid}, 32'd1);
            chk("sv_if_valid", {31'd0, if_valid}, 32'd0);
            tick();
        end
        bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("sv_idle5", {31'd0, u_bus.bus_req}, 32'd0);
        tick(); bus_drv(1'b1, 1'b1, 32'h22); #1;
        chk("sv_if_addr", u_bus.bus_addr, 32'h200);
        chk("sv_if_valid5", {31'd0, if_valid}, 32'd1);
        chk("sv_mem_valid5", {31'd0, mem_valid}, 32'd0);
        chk("sv_stall_mem5", {31'd0, stall_mem}, 32'd1);
        tick(); bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("sv_idle6", {31'd0, u_bus.bus_req}, 32'd0);
        tick(); bus_drv(1'b1, 1'b1, 32'h33); #1;
        chk("sv_reset_streak_addr", u_bus.bus_addr, 32'h4000);
        chk("sv_reset_streak_valid", {31'd0, mem_valid}, 32'd1);
        tick(); if_req = 1'b0; mem_req = 1'b0; bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("sv_conflict", conflict_cnt, 32'd14);

        // Kill during wait
        tick(); if_req = 1'b1; if_addr = 32'h300; #1;
        tick(); bus_drv(1'b1, 1'b0, 32'h0); #1;
        chk("k_bus_addr", u_bus.bus_addr, 32'h300);
        tick();
        if_kill = 1'b1; if_req = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000;
        bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("k_if_valid_kill", {31'd0, if_valid}, 32'd0);
        chk("k_stall_mem", {31'd0, stall_mem}, 32'd1);
        tick(); if_kill = 1'b0; #1;
        chk("k_drain_bus_req", {31'd0, u_bus.bus_req}, 32'd0);
        chk("k_drain_mem_valid", {31'd0, mem_valid}, 32'd0);
        tick(); bus_drv(1'b0, 1'b1, 32'hBAD0BAD0); #1;
        chk("k_drain_if_valid", {31'd0, if_valid}, 32'd0);
        chk("k_drain_mem_valid2", {31'd0, mem_valid}, 32'd0);
        chk("k_drain_bus_req2", {31'd0, u_bus.bus_req}, 32'd0);
        tick(); bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("k_idle_bus_req", {31'd0, u_bus.bus_req}, 32'd0);
        tick(); bus_drv(1'b1, 1'b1, 32'h55); #1;
        chk("k_mem_bus_req", {31'd0, u_bus.bus_req}, 32'd1);
        chk("k_mem_addr", u_bus.bus_addr, 32'h5000);
        chk("k_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("k_mem_rdata", mem_rdata, 32'h55);

        // Bus back-pressure on a load from 0x3004
        tick(); mem_addr = 32'h3004; bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("bp_stall_idle", {31'd0, stall_mem}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("bp_bus_req", {31'd0, u_bus.bus_req}, 32'd1);
            chk("bp_bus_addr", u_bus.bus_addr, 32'h3004);
            chk("bp_stall_mem", {31'd0, stall_mem}, 32'd1);
            chk("bp_mem_valid", {31'd0, mem_valid}, 32'd0);
        end
        tick(); bus_drv(1'b1, 1'b0, 32'h0); #1;
        chk("bp_gnt_addr", u_bus.bus_addr, 32'h3004);
        chk("bp_gnt_stall", {31'd0, stall_mem}, 32'd1);
        tick(); bus_drv(1'b0, 1'b1, 32'hCAFEF00D); #1;
        chk("bp_mem_valid_done", {31'd0, mem_valid}, 32'd1);
        chk("bp_mem_rdata", mem_rdata, 32'hCAFEF00D);
        chk("bp_stall_done", {31'd0, stall_mem}, 32'd0);
        tick(); mem_req = 1'b0; bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("bp_valid_once", {31'd0, mem_valid}, 32'd0);

        // Reset in WAIT_MEM
        tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h6000;
        if_req = 1'b1; if_addr = 32'h400; #1;
        tick(); bus_drv(1'b1, 1'b0, 32'h0); #1;
        chk("r_bus_req", {31'd0, u_bus.bus_req}, 32'd1);
        tick(); bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("r_conflict_pre", conflict_cnt, 32'd16);
        rst = 1'b0; bus_drv(1'b0, 1'b1, 32'h77); #1;
        chk("r_bus_req_rst", {31'd0, u_bus.bus_req}, 32'd0);
        chk("r_mem_valid_rst", {31'd0, mem_valid}, 32'd0);
        chk("r_if_valid_rst", {31'd0, if_valid}, 32'd0);
        chk("r_conflict_rst", conflict_cnt, 32'd0);
        tick(); rst = 1'b1; mem_req = 1'b0; if_req = 1'b0; bus_drv(1'b0, 1'b1, 32'h88); #1;
        chk("r_stray_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("r_stray_if_valid", {31'd0, if_valid}, 32'd0);
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 32'h7000; mem_wdata = 32'h12345678;
        bus_drv(1'b0, 1'b0, 32'h0); #1;
        tick(); bus_drv(1'b1, 1'b1, 32'h0); #1;
        chk("r_post_we", {31'd0, u_bus.bus_we}, 32'd1);
        chk("r_post_be", {28'd0, u_bus.bus_be}, 32'h3);
        chk("r_post_addr", u_bus.bus_addr, 32'h7000);
        chk("r_post_wdata", u_bus.bus_wdata, 32'h12345678);
        chk("r_post_valid", {31'd0, mem_valid}, 32'd1);
        tick(); mem_req = 1'b0; bus_drv(1'b0, 1'b0, 32'h0); #1;
        chk("r_post_conflict", conflict_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between two requesters: the fetch stage (instruction reads) and the memory stage (loads and stores).
- Issues at most one outstanding bus transaction at a time.
- Fixed priority to the memory stage, with an anti-starvation limit for fetch.
- Drives per-stage stall signals into the hazard logic, and counts contention cycles for the performance counters.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits (byte-enable width is DW/8).
- MAX_MEM_STREAK, 4, maximum consecutive memory-stage grants while a fetch is pending; the next grant must go to fetch. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch read request, held until if_valid.
- if_addr  input  AW  fetch byte address.
- if_kill  input  1  pipeline flush; discard the in-flight or pending fetch.
- if_valid  output  1  fetch data valid, one cycle.
- if_rdata  output  DW  instruction word.
- mem_req  input  1  memory-stage request, held until mem_valid.
- mem_we  input  1  1 = store, 0 = load.
- mem_be  input  DW/8  byte enables for the store.
- mem_addr  input  AW  data byte address.
- mem_wdata  input  DW  store data.
- mem_valid  output  1  load data valid or store acknowledged, one cycle.
- mem_rdata  output  DW  load data.
- bus_req  output  1  bus request.
- bus_we  output  1  bus write enable.
- bus_be  output  DW/8  bus byte enables.
- bus_addr  output  AW  bus address.
- bus_wdata  output  DW  bus write data.
- bus_gnt  input  1  bus accepted the request this cycle.
- bus_rvalid  input  1  bus response (read data or write ack).
- bus_rdata  input  DW  bus read data.
- stall_if  output  1  hold the fetch stage.
- stall_mem  output  1  hold the memory stage and everything upstream of it.
- conflict_cnt  output  32  cycles in which both if_req and mem_req were high.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE; streak counter and conflict_cnt clear to 0.
  - All bus_* outputs are 0; if_valid and mem_valid are 0.
  - stall_if and stall_mem follow their combinational definitions from inputs, so both are 0 whenever no request is asserted.
- States:
  - IDLE: no transaction outstanding.
  - REQ_IF / REQ_MEM: bus_req asserted, waiting for bus_gnt.
  - WAIT_IF / WAIT_MEM: accepted, waiting for bus_rvalid.
  - DRAIN: a killed fetch is still outstanding.
- Arbitration in IDLE, registered into REQ_x on the next edge:
  - Grant MEM if mem_req=1 and not (if_req=1 and streak==MAX_MEM_STREAK).
  - Otherwise grant IF if if_req=1 and if_kill=0.
- Streak counter:
  - Increments on each MEM grant while if_req=1; saturates at MAX_MEM_STREAK.
  - Clears on any IF grant, and whenever if_req=0.
- REQ_x:
  - bus_req=1, and bus_we/be/addr/wdata are registered from the granted requester.
  - bus_* are held stable until bus_gnt=1, then move to WAIT_x.
  - If bus_gnt and bus_rvalid are both 1 in the same cycle, complete directly and go to IDLE.
  - For an IF grant, bus_we=0 and bus_be is all ones.
- WAIT_x:
  - On bus_rvalid, pulse x_valid combinationally in that same cycle, with x_rdata = bus_rdata.
  - Next state is IDLE. Minimum request-to-valid latency is 2 cycles (arbitrate, then issue with same-cycle gnt+rvalid).
- if_kill:
  - In REQ_IF: drop bus_req next cycle and return to IDLE.
  - In WAIT_IF: go to DRAIN, and suppress if_valid for that response.
  - In DRAIN: on bus_rvalid go to IDLE with no valid output.
  - In IDLE: inhibits an IF grant that cycle.
- Stalls:
  - stall_mem = mem_req & ~mem_valid.
  - stall_if = (if_req & ~if_valid) | stall_mem.
- conflict_cnt: increments on every cycle with if_req & mem_req, wraps modulo 2^32.
- Stray bus_rvalid in IDLE or REQ_x is ignored.
- if_valid and mem_valid are never asserted in the same cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum arb_state_t (IDLE, REQ_IF, REQ_MEM, WAIT_IF, WAIT_MEM, DRAIN);
  - the owner enum owner_t (OWN_IF, OWN_MEM).
- One sub-module, arb_streak_ctr: a saturating streak counter with an at_limit output.
- The FSM, the bus request register and conflict_cnt stay in the top module.

Test Plan:
- Lone fetch:
  - Stimulus: if_req=1, if_addr=0x100; bus gnt immediate, rvalid 1 cycle later with 0x00500093.
  - Required: if_valid=1 exactly once with if_rdata=0x00500093; bus_we=0; stall_if high until that cycle.
- Simultaneous requests:
  - Stimulus: if_req and mem_req both 1 (store 0xDEADBEEF to 0x2000, mem_be=4'b1111).
  - Required: store is issued first, with bus_we=1 and bus_addr=0x2000; the fetch is issued after mem_valid; conflict_cnt=2 at the end.
- Starvation limit (MAX_MEM_STREAK=4):
  - Stimulus: mem_req held high continuously, if_req held high.
  - Required: after the 4th MEM grant the next grant is IF; the streak then resets.
- Kill during wait:
  - Stimulus: fetch accepted, then if_kill=1 before bus_rvalid.
  - Required: FSM goes to DRAIN, no if_valid for the returning data; a following mem_req is granted only after the drain completes.
- Bus back-pressure:
  - Stimulus: bus_gnt held low for 3 cycles on a load from 0x3004.
  - Required: bus_addr and bus_req are stable for all 3 cycles; mem_valid arrives after rvalid; stall_mem is high throughout.
- Reset mid-transaction:
  - Stimulus: drive rst=0 in WAIT_MEM.
  - Required: bus_req=0 and both valids 0 immediately; conflict_cnt=0; normal operation after rst returns to 1.
